// File: rtl/lsu_hs.sv
// Handshaked load/store unit: request/grant/response memory port with lane alignment.
// Optional bus-timeout trap enabled by defining LSU_TIMEOUT_EN.
module lsu_hs #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_done,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_trap,
  output logic              o_busy,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_mask,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [OW-1:0]   off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            load_q;

  logic            accept;
  logic [OW-1:0]   off;
  logic [2:0]      amask;
  logic [7:0]      lanes;
  logic            illegal;
  logic            misal;
  logic            tmo;

  assign o_ready = (state == S_IDLE);
  assign o_busy  = (state != S_IDLE);
  assign accept  = i_valid & o_ready;
  assign off     = i_addr[OW-1:0];

  always_comb begin
    amask = 3'b000;
    lanes = 8'h01;
    unique case (i_size)
      2'b00: begin amask = 3'b000; lanes = 8'h01; end
      2'b01: begin amask = 3'b001; lanes = 8'h03; end
      2'b10: begin amask = 3'b011; lanes = 8'h0f; end
      2'b11: begin amask = 3'b111; lanes = 8'hff; end
    endcase
  end

  assign illegal = (i_load == i_store)
                 | ((XLEN == 32) && (i_size == 2'b11));
  assign misal   = |(i_addr[2:0] & amask);

  // Left-justify the field, then shift back down logically or arithmetically.
  logic [XLEN-1:0]        ld_sh;
  logic [XLEN-1:0]        ld_top;
  logic signed [XLEN-1:0] ld_s;
  logic [XLEN-1:0]        ld_val;
  logic [6:0]             ld_k;

  always_comb begin
    ld_sh  = i_mem_rdata >> {off_q, 3'b000};
    ld_k   = 7'(XLEN) - (7'd8 << size_q);
    ld_top = ld_sh << ld_k;
    ld_s   = $signed(ld_top) >>> ld_k;
    ld_val = uns_q ? (ld_top >> ld_k) : ld_s;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt;

  assign tmo = (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tcnt <= '0;
    end else if (accept) begin
      tcnt <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      off_q       <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      o_done      <= 1'b0;
      o_trap      <= 1'b0;
      o_rdata     <= '0;
      o_mem_req   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_mask  <= '0;
    end else begin
      o_done <= 1'b0;
      o_trap <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (illegal | misal) begin
              state   <= S_DONE;
              o_done  <= 1'b1;
              o_trap  <= 1'b1;
              o_rdata <= '0;
            end else begin
              state       <= S_REQ;
              off_q       <= off;
              size_q      <= i_size;
              uns_q       <= i_unsigned;
              load_q      <= i_load;
              o_mem_req   <= 1'b1;
              o_mem_wen   <= i_store;
              o_mem_addr  <= i_addr & ~XLEN'(NB - 1);
              o_mem_mask  <= NB'(lanes) << off;
              o_mem_wdata <= i_wdata << {off, 3'b000};
            end
          end
        end
        S_REQ: begin
          if (tmo) begin
            state     <= S_DONE;
            o_mem_req <= 1'b0;
            o_done    <= 1'b1;
            o_trap    <= 1'b1;
            o_rdata   <= '0;
          end else if (i_mem_gnt) begin
            state     <= S_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (tmo) begin
            state   <= S_DONE;
            o_done  <= 1'b1;
            o_trap  <= 1'b1;
            o_rdata <= '0;
          end else if (i_mem_rvalid) begin
            state   <= S_DONE;
            o_done  <= 1'b1;
            o_rdata <= load_q ? ld_val : '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: 32- and 64-bit instances, scoreboard of results.
// Define LSU_TIMEOUT_EN for both RTL and bench to exercise the timeout trap.
module tb_lsu_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        ld = 1'b0;
  logic        st = 1'b0;
  logic        uns = 1'b0;
  logic        gnt = 1'b0;
  logic        rv = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata = '0;

  always #5 clk = ~clk;

  logic        rdy32, dn32, tr32, bz32, rq32, we32;
  logic [31:0] rd32, ma32, wd32;
  logic [3:0]  mk32;
  logic        rdy64, dn64, tr64, bz64, rq64, we64;
  logic [63:0] rd64, ma64, wd64;
  logic [7:0]  mk64;

  lsu_hs #(.XLEN(32), .TIMEOUT_CYCLES(8)) u32 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid & ~sel),
    .o_ready      (rdy32),
    .i_load       (ld),
    .i_store      (st),
    .i_size       (sz),
    .i_unsigned   (uns),
    .i_addr       (addr[31:0]),
    .i_wdata      (wdata[31:0]),
    .o_done       (dn32),
    .o_rdata      (rd32),
    .o_trap       (tr32),
    .o_busy       (bz32),
    .o_mem_req    (rq32),
    .i_mem_gnt    (gnt),
    .o_mem_addr   (ma32),
    .o_mem_wen    (we32),
    .o_mem_wdata  (wd32),
    .o_mem_mask   (mk32),
    .i_mem_rvalid (rv),
    .i_mem_rdata  (rdata[31:0])
  );

  lsu_hs #(.XLEN(64)) u64 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid & sel),
    .o_ready      (rdy64),
    .i_load       (ld),
    .i_store      (st),
    .i_size       (sz),
    .i_unsigned   (uns),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_done       (dn64),
    .o_rdata      (rd64),
    .o_trap       (tr64),
    .o_busy       (bz64),
    .o_mem_req    (rq64),
    .i_mem_gnt    (gnt),
    .o_mem_addr   (ma64),
    .o_mem_wen    (we64),
    .o_mem_wdata  (wd64),
    .o_mem_mask   (mk64),
    .i_mem_rvalid (rv),
    .i_mem_rdata  (rdata)
  );

  logic        m_done, m_trap, m_busy, m_ready, m_req, m_wen;
  logic [63:0] m_rdata, m_addr, m_wd;
  logic [7:0]  m_mask;

  always_comb begin
    if (sel) begin
      m_done  = dn64;  m_trap = tr64;  m_busy = bz64;
      m_ready = rdy64; m_req  = rq64;  m_wen  = we64;
      m_rdata = rd64;  m_addr = ma64;  m_wd   = wd64;
      m_mask  = mk64;
    end else begin
      m_done  = dn32;  m_trap = tr32;  m_busy = bz32;
      m_ready = rdy32; m_req  = rq32;  m_wen  = we32;
      m_rdata = {32'b0, rd32};
      m_addr  = {32'b0, ma32};
      m_wd    = {32'b0, wd32};
      m_mask  = {4'b0, mk32};
    end
  end

  typedef struct {
    logic [63:0] rd;
    logic        tr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, m_ready, 1);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_trap"}, m_trap, 0);
    chk({tag, "_req"}, m_req, 0);
    chk({tag, "_wen"}, m_wen, 0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_wd"}, m_wd, 0);
    chk({tag, "_mask"}, m_mask, 0);
    chk({tag, "_rdata"}, m_rdata, 0);
  endtask

  task automatic wait_done_pop(input string tag, input int lat, inout int cyc);
    exp_t e;
    int   n;
    n = 0;
    while (!m_done && n < 20) begin
      tick();
      n++;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    if (m_done && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, m_rdata, e.rd);
      chk({tag, "_trap"}, m_trap, e.tr);
    end else begin
      chk({tag, "_done_seen"}, m_done, 1);
    end
    tick();
    chk({tag, "_pulse"}, m_done, 0);
    chk({tag, "_idle"}, m_ready, 1);
  endtask

  task automatic do_op(input string tag, input bit s, input bit l,
                       input bit t, input logic [1:0] z, input bit u,
                       input logic [63:0] a, input logic [63:0] wd,
                       input int gdly, input logic [63:0] rd, input bit mem,
                       input logic [63:0] ea, input logic [7:0] em,
                       input logic [63:0] ewd, input logic [63:0] er,
                       input bit et);
    int cyc;
    exp_t e;
    sel = s;
    #1;
    chk({tag, "_ready"}, m_ready, 1);
    valid = 1'b1; ld = l; st = t; sz = z; uns = u;
    addr = a; wdata = wd;
    tick();
    valid = 1'b0;
    e.rd = er;
    e.tr = et;
    sb.push_back(e);
    cyc = 1;
    if (mem) begin
      chk({tag, "_req"}, m_req, 1);
      chk({tag, "_maddr"}, m_addr, ea);
      chk({tag, "_mask"}, m_mask, em);
      chk({tag, "_wen"}, m_wen, t);
      if (t) chk({tag, "_wdata"}, m_wd, ewd);
      for (int i = 0; i < gdly; i++) begin
        tick();
        cyc++;
        chk({tag, "_req_hold"}, {m_req, m_busy, m_mask, m_addr},
            {1'b1, 1'b1, em, ea});
      end
      gnt = 1'b1;
      tick();
      cyc++;
      gnt = 1'b0;
      chk({tag, "_req_drop"}, m_req, 0);
      chk({tag, "_busy"}, m_busy, 1);
      rv = 1'b1;
      rdata = rd;
      tick();
      cyc++;
      rv = 1'b0;
      wait_done_pop(tag, 3 + gdly, cyc);
    end else begin
      chk({tag, "_noreq"}, m_req, 0);
      wait_done_pop(tag, 1, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    exp_t e;
    repeat (2) tick();
    sel = 1'b0;
    #1;
    chk_reset("rst32");
    sel = 1'b1;
    #1;
    chk_reset("rst64");
    rst_n = 1'b1;
    tick();

    do_op("lw", 0, 1, 0, 2'b10, 0, 64'h1000, 0, 0, 64'hDEADBEEF, 1,
          64'h1000, 8'h0f, 0, 64'hDEADBEEF, 0);
    do_op("lb", 0, 1, 0, 2'b00, 0, 64'h2003, 0, 0, 64'h80000000, 1,
          64'h2000, 8'h08, 0, 64'hFFFFFF80, 0);
    do_op("lbu", 0, 1, 0, 2'b00, 1, 64'h2003, 0, 0, 64'h80000000, 1,
          64'h2000, 8'h08, 0, 64'h00000080, 0);
    do_op("sh", 0, 0, 1, 2'b01, 0, 64'h3002, 64'hABCD, 0, 64'h0, 1,
          64'h3000, 8'h0c, 64'hABCD0000, 64'h0, 0);
    do_op("lh", 0, 1, 0, 2'b01, 0, 64'h2002, 0, 2, 64'h80011234, 1,
          64'h2000, 8'h0c, 0, 64'hFFFF8001, 0);
    do_op("sb", 0, 0, 1, 2'b00, 0, 64'h1001, 64'h5A, 1, 64'h0, 1,
          64'h1000, 8'h02, 64'h5A00, 64'h0, 0);
    do_op("lw_mis", 0, 1, 0, 2'b10, 0, 64'h1002, 0, 0, 0, 0,
          0, 0, 0, 64'h0, 1);
    do_op("ldst", 0, 1, 1, 2'b10, 0, 64'h1000, 0, 0, 0, 0,
          0, 0, 0, 64'h0, 1);
    do_op("none", 0, 0, 0, 2'b00, 0, 64'h1000, 0, 0, 0, 0,
          0, 0, 0, 64'h0, 1);
    do_op("ld32", 0, 1, 0, 2'b11, 0, 64'h1000, 0, 0, 0, 0,
          0, 0, 0, 64'h0, 1);

    do_op("ld64", 1, 1, 0, 2'b11, 0, 64'h10, 0, 5, 64'h0123456789ABCDEF, 1,
          64'h10, 8'hff, 0, 64'h0123456789ABCDEF, 0);
    do_op("lw64", 1, 1, 0, 2'b10, 0, 64'h14, 0, 0, 64'h80000000_12345678, 1,
          64'h10, 8'hf0, 0, 64'hFFFFFFFF80000000, 0);
    do_op("lwu64", 1, 1, 0, 2'b10, 1, 64'h14, 0, 0, 64'h80000000_12345678, 1,
          64'h10, 8'hf0, 0, 64'h0000000080000000, 0);
    do_op("sd64", 1, 0, 1, 2'b11, 0, 64'h8, 64'h1122334455667788, 0, 0, 1,
          64'h8, 8'hff, 64'h1122334455667788, 64'h0, 0);
    do_op("ld64_mis", 1, 1, 0, 2'b11, 0, 64'h14, 0, 0, 0, 0,
          0, 0, 0, 64'h0, 1);

    // Reset while waiting for a response; the late response must be dropped.
    sel = 1'b0;
    valid = 1'b1; ld = 1'b1; st = 1'b0; sz = 2'b10; uns = 1'b0;
    addr = 64'h4000;
    tick();
    valid = 1'b0;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("mid_busy", m_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    rv = 1'b1;
    rdata = 64'h12345678;
    tick();
    rv = 1'b0;
    chk("late_rv_done", m_done, 0);
    chk("late_rv_idle", {m_ready, m_busy}, 2'b10);
    tick();
    chk("late_rv_done2", m_done, 0);

`ifdef LSU_TIMEOUT_EN
    sel = 1'b0;
    valid = 1'b1; ld = 1'b1; st = 1'b0; sz = 2'b10; uns = 1'b0;
    addr = 64'h1000;
    tick();
    valid = 1'b0;
    e.rd = 64'h0;
    e.tr = 1'b1;
    sb.push_back(e);
    cyc = 1;
    chk("tmo_req", m_req, 1);
    wait_done_pop("tmo", 9, cyc);
    chk("tmo_req_drop", m_req, 0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rv = 1'b1;
    tick();
    rv = 1'b0;
    chk("tmo_late", {m_done, m_ready}, 2'b01);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Handshaked load/store unit for the next-generation hart. It replaces the combinational dmem path with a request/grant/response memory port that tolerates variable latency.
- Accepts one memory operation at a time from the execute stage and performs byte-lane alignment, masking and sign/zero extension.
- Detects misalignment and illegal sizes, and reports completion with a one-cycle done pulse. The hart stalls retire while o_busy is high.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT_CYCLES, 64, cycles spent in REQ+WAIT before a bus-timeout trap (used only with LSU_TIMEOUT_EN).

Ports:
- i_clk  input  1  global clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  operation request from hart.
- o_ready  output  1  high only in IDLE; accept = i_valid & o_ready at the clock edge.
- i_load  input  1  operation is a load.
- i_store  input  1  operation is a store.
- i_size  input  2  00 byte, 01 half, 10 word, 11 dword.
- i_unsigned  input  1  zero-extend load result.
- i_addr  input  XLEN  byte address.
- i_wdata  input  XLEN  store data, right-justified.
- o_done  output  1  one-cycle completion pulse.
- o_rdata  output  XLEN  extended load result; valid with o_done.
- o_trap  output  1  valid with o_done; misaligned, illegal or timeout.
- o_busy  output  1  high whenever state is not IDLE.
- o_mem_req  output  1  memory request, held until grant.
- i_mem_gnt  input  1  memory accepted the request this cycle.
- o_mem_addr  output  XLEN  address aligned to XLEN/8 bytes.
- o_mem_wen  output  1  1 = write, 0 = read.
- o_mem_wdata  output  XLEN  store data shifted into its byte lanes.
- o_mem_mask  output  XLEN/8  byte-lane enables.
- i_mem_rvalid  input  1  response (read data or write ack).
- i_mem_rdata  input  XLEN  read data, full aligned word.

Behaviour:
- Reset (async on i_rst_n low):
  - state IDLE.
  - o_done, o_trap, o_busy, o_mem_req, o_mem_wen = 0.
  - o_rdata, o_mem_addr, o_mem_wdata, o_mem_mask = 0.
  - Reset mid-operation abandons the transfer. A late i_mem_rvalid/i_mem_gnt arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on accept, the operation is classified.
  - Illegal if i_load == i_store (both or neither), or size 11 with XLEN=32.
  - Misaligned if the address is not a multiple of 2^i_size.
  - Illegal or misaligned: go to DONE with trap = 1 and issue no memory request.
  - Otherwise latch the operation, drive the memory outputs and go to REQ.
- Memory outputs are registered:
  - off = addr mod XLEN/8.
  - o_mem_addr = addr with its low log2(XLEN/8) bits cleared.
  - o_mem_mask = ((1<<2^size)-1) << off.
  - o_mem_wdata = wdata << 8*off.
  - o_mem_wen = store.
- REQ: o_mem_req = 1 with address, data and mask stable. On i_mem_gnt, deassert the request and go to WAIT.
- WAIT: on i_mem_rvalid, go to DONE.
  - Load: o_rdata = (i_mem_rdata >> 8*off), truncated to 8·2^size bits, then sign-extended (i_unsigned = 0) or zero-extended.
  - A word load on XLEN=32 and a dword load on XLEN=64 ignore i_unsigned.
  - Store: o_rdata = 0.
- DONE: o_done = 1 for exactly one cycle, with o_trap valid. Next state is IDLE, where o_ready = 1. A new operation can be accepted on the edge ending the cycle after DONE.
- Timing:
  - Minimum latency is accept edge → o_done high 3 cycles later: req in cycle 1 with gnt, rvalid in cycle 2, done in cycle 3.
  - Trap latency is 1 cycle.
- i_mem_rvalid in REQ is ignored. A response is legal no earlier than the cycle after gnt.
- Inputs other than i_mem_* are don't-care while o_busy = 1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on accept and increments each cycle in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES forces DONE with o_trap = 1 and o_rdata = 0, and drops o_mem_req the same cycle.
  - A later i_mem_rvalid is ignored.
- Without the macro: no counter exists, and REQ/WAIT wait indefinitely.

Test Plan:
- XLEN=32, lw at 0x1000, gnt same cycle as req, rvalid next cycle with 0xDEADBEEF → o_mem_addr 0x1000, mask 1111, o_done 3 cycles after accept, o_rdata 0xDEADBEEF, o_trap 0.
- lb at 0x2003, rdata 0x80000000 → mask 1000, o_rdata 0xFFFFFF80. The same access as lbu → 0x00000080.
- sh at 0x3002 with wdata 0x0000ABCD → o_mem_wen 1, mask 1100, o_mem_wdata 0xABCD0000, done after write ack.
- lw at 0x1002, then i_load=i_store=1 → each gives o_done one cycle after accept with o_trap 1 and o_mem_req never asserted.
- XLEN=64, ld at 0x10 with i_mem_gnt delayed 5 cycles → o_mem_req held stable for 6 cycles, mask 0xFF, o_busy high throughout. Then lw at 0x14, rdata 0x8000_0000_xxxx_xxxx → o_rdata 0xFFFFFFFF80000000.
- i_rst_n low in WAIT, then rvalid arrives after reset release → outputs zero, state IDLE, no o_done. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no gnt → o_trap with o_done at cycle 9 after accept.
